// File: rtl/fetch_pkg.sv
// Shared defaults and types for the fetch-stage front end.
package fetch_pkg;

    localparam int DEFAULT_ADDRESS_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH    = 32;
    localparam logic [DEFAULT_ADDRESS_WIDTH-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [DEFAULT_DATA_WIDTH-1:0]    NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic [DEFAULT_ADDRESS_WIDTH-1:0] pc;
        logic [DEFAULT_DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO holding fetched {pc, instr} entries; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= wdata;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign rdata = storage[rd_ptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register driving instruction memory, fetch queue toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
    parameter int QUEUE_DEPTH   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     dec_valid,
    input  logic                     dec_ready,
    output logic [DATA_WIDTH-1:0]    dec_instr,
    output logic [ADDRESS_WIDTH-1:0] dec_pc,
    output logic [ADDRESS_WIDTH-1:0] dec_pc_plus4
);

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } entry_t;

    function automatic logic [ADDRESS_WIDTH-1:0] next_seq_pc(input logic [ADDRESS_WIDTH-1:0] a);
        return a + ADDRESS_WIDTH'(4);
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] word_align(input logic [ADDRESS_WIDTH-1:0] a);
        return {a[ADDRESS_WIDTH-1:2], 2'b00};
    endfunction

    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     enq;
    logic                     deq;
    logic                     q_full;
    logic                     q_empty;
    entry_t                   wr_entry;
    entry_t                   head_entry;

    // Handshake: dec_ready feeds straight into the PC enable so a full queue
    // can still accept a new entry in the cycle its head is consumed.
    assign dec_valid = !q_empty && !redirect_valid && rst_n;
    assign deq       = dec_valid && dec_ready;
    assign enq       = !redirect_valid && (!q_full || deq);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (enq) begin
            pc <= next_seq_pc(pc);
        end
    end

    assign imem_addr      = pc;
    assign wr_entry.pc    = pc;
    assign wr_entry.instr = imem_instr;

    fetch_queue #(
        .WIDTH (ADDRESS_WIDTH + DATA_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (enq),
        .pop   (deq),
        .wdata (wr_entry),
        .rdata (head_entry),
        .full  (q_full),
        .empty (q_empty)
    );

    assign dec_instr    = head_entry.instr;
    assign dec_pc       = head_entry.pc;
    assign dec_pc_plus4 = next_seq_pc(head_entry.pc);

endmodule
